// File: rtl/text_pkg.sv
// text_pkg: constants shared by the text-mode writer, its buffer RAM and the
// character PPU.
//   TEXTCOL / TEXTROW : text grid size (1024/8/2 x 600/8/2)
//   ADDRW             : buffer address width, address = row*TEXTCOL + col
//   CH_*              : control / fill character codes
//   state_t           : writer FSM states
package text_pkg;

  localparam int unsigned TEXTCOL = 64;
  localparam int unsigned TEXTROW = 37;
  localparam int unsigned ADDRW   = $clog2(TEXTCOL * TEXTROW);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_DEL   = 8'h7F;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_SCROLL   = 3'd2,
    ST_CLR_LINE = 3'd3,
    ST_CLR_ALL  = 3'd4
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_SPACE) && (c != CH_DEL);
  endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// text_buffer_ram: COLS*ROWS x 8 text buffer, synchronous reads, contents
// start as spaces.
//   clk_pix                     : sole clock
//   a_we/a_waddr/a_wdata        : writer write port
//   a_raddr -> a_rdata          : writer read port (used while scrolling)
//   b_addr  -> b_rdata          : PPU read port
// Reads return the old contents when the same cycle writes a different
// address, which the scroll copy relies on.
module text_buffer_ram #(
  parameter int unsigned COLS  = text_pkg::TEXTCOL,
  parameter int unsigned ROWS  = text_pkg::TEXTROW,
  parameter int unsigned ADDRW = $clog2(COLS * ROWS)
) (
  input  logic             clk_pix,
  input  logic             a_we,
  input  logic [ADDRW-1:0] a_waddr,
  input  logic [7:0]       a_wdata,
  input  logic [ADDRW-1:0] a_raddr,
  output logic [7:0]       a_rdata,
  input  logic [ADDRW-1:0] b_addr,
  output logic [7:0]       b_rdata
);
  import text_pkg::*;

  localparam int unsigned CELLS = COLS * ROWS;

  logic [7:0] mem [CELLS] = '{default: CH_SPACE};

  always_ff @(posedge clk_pix) begin
    if (a_we) mem[a_waddr] <= a_wdata;
    a_rdata <= mem[a_raddr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/text_writer.sv
// text_writer: byte-stream writer for the text buffer with cursor tracking,
// BS/LF/FF/CR handling and hardware scroll.
//   clk_pix, rst_pix          : clock, synchronous active-high reset
//   in_valid/in_ready/in_char : byte input handshake (ready only in IDLE)
//   buf_we/buf_addr/buf_wdata : buffer write port
//   buf_rd_addr/buf_rdata     : buffer read port, data one cycle after addr
//   cursor_col/cursor_row     : current cursor position
//   busy                      : any state other than IDLE
module text_writer #(
  parameter int unsigned COLS  = text_pkg::TEXTCOL,
  parameter int unsigned ROWS  = text_pkg::TEXTROW,
  parameter int unsigned ADDRW = $clog2(COLS * ROWS)
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_char,
  output logic                    buf_we,
  output logic [ADDRW-1:0]        buf_addr,
  output logic [7:0]              buf_wdata,
  output logic [ADDRW-1:0]        buf_rd_addr,
  input  logic [7:0]              buf_rdata,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    busy
);
  import text_pkg::*;

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);

  localparam logic [CW-1:0]    COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);
  localparam logic [ADDRW-1:0] A_COLS    = ADDRW'(COLS);
  localparam logic [ADDRW-1:0] A_NCOPY   = ADDRW'((ROWS - 1) * COLS);
  localparam logic [ADDRW-1:0] A_LAST    = ADDRW'(COLS * ROWS - 1);
  localparam logic [ADDRW-1:0] A_ONE     = ADDRW'(1);

  state_t           state;
  state_t           after_write;
  logic [ADDRW-1:0] line_base;   // cursor_row * COLS, kept incrementally
  logic [ADDRW-1:0] step;        // SCROLL cycle index 0..N
  logic [7:0]       wdata_q;
  logic [ADDRW-1:0] col_addr;

  assign col_addr = line_base + ADDRW'(cursor_col);
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // The scroll copy writes the byte the RAM returns this cycle, so write data
  // comes straight from the RAM read register while scrolling.
  assign buf_wdata = (state == ST_SCROLL) ? buf_rdata : wdata_q;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state       <= ST_IDLE;
      after_write <= ST_IDLE;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      wdata_q     <= CH_SPACE;
      buf_rd_addr <= '0;
      cursor_col  <= '0;
      cursor_row  <= '0;
      line_base   <= '0;
      step        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          buf_we <= 1'b0;
          if (in_valid) begin
            state       <= ST_WRITE;
            after_write <= ST_IDLE;
            if (is_printable(in_char)) begin
              buf_we   <= 1'b1;
              buf_addr <= col_addr;
              wdata_q  <= in_char;
              if (cursor_col == COL_LAST) begin
                cursor_col <= '0;
                if (cursor_row == ROW_LAST) begin
                  after_write <= ST_SCROLL;
                end else begin
                  cursor_row <= cursor_row + RW'(1);
                  line_base  <= line_base + A_COLS;
                end
              end else begin
                cursor_col <= cursor_col + CW'(1);
              end
            end else begin
              case (in_char)
                CH_LF: begin
                  cursor_col <= '0;
                  if (cursor_row == ROW_LAST) begin
                    after_write <= ST_SCROLL;
                  end else begin
                    cursor_row <= cursor_row + RW'(1);
                    line_base  <= line_base + A_COLS;
                  end
                end
                CH_CR: cursor_col <= '0;
                CH_BS: begin
                  if (cursor_col != '0) begin
                    cursor_col <= cursor_col - CW'(1);
                    buf_we     <= 1'b1;
                    buf_addr   <= col_addr - A_ONE;
                    wdata_q    <= CH_SPACE;
                  end else if (cursor_row != '0) begin
                    // last column of the previous row is line_base - 1
                    cursor_col <= COL_LAST;
                    cursor_row <= cursor_row - RW'(1);
                    line_base  <= line_base - A_COLS;
                    buf_we     <= 1'b1;
                    buf_addr   <= line_base - A_ONE;
                    wdata_q    <= CH_SPACE;
                  end
                end
                CH_FF: begin
                  cursor_col  <= '0;
                  cursor_row  <= '0;
                  line_base   <= '0;
                  after_write <= ST_CLR_ALL;
                end
                default: ;
              endcase
            end
          end
        end

        ST_WRITE: begin
          state  <= after_write;
          buf_we <= 1'b0;
          if (after_write == ST_SCROLL) begin
            step        <= '0;
            buf_rd_addr <= A_COLS;
          end else if (after_write == ST_CLR_ALL) begin
            buf_we   <= 1'b1;
            buf_addr <= '0;
            wdata_q  <= CH_SPACE;
          end
        end

        // Cycle k reads k+COLS; cycle k+1 writes k with that data.
        ST_SCROLL: begin
          if (step == A_NCOPY) begin
            state    <= ST_CLR_LINE;
            buf_we   <= 1'b1;
            buf_addr <= A_NCOPY;
            wdata_q  <= CH_SPACE;
          end else begin
            buf_we   <= 1'b1;
            buf_addr <= step;
            step     <= step + A_ONE;
            if ((step + A_ONE) < A_NCOPY) buf_rd_addr <= step + A_COLS + A_ONE;
          end
        end

        // Both clears run up to the last cell of the buffer.
        ST_CLR_LINE, ST_CLR_ALL: begin
          if (buf_addr == A_LAST) begin
            state  <= ST_IDLE;
            buf_we <= 1'b0;
          end else begin
            buf_addr <= buf_addr + A_ONE;
          end
        end

        default: begin
          state  <= ST_IDLE;
          buf_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: directed bench for text_writer with text_buffer_ram beside
// it; buffer contents are read back through the RAM's PPU port.
module tb_text_writer;

  localparam int unsigned COLS  = 64;
  localparam int unsigned ROWS  = 37;
  localparam int unsigned CELLS = COLS * ROWS;

  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        buf_we;
  logic [11:0] buf_addr;
  logic [7:0]  buf_wdata;
  logic [11:0] buf_rd_addr;
  logic [7:0]  buf_rdata;
  logic [5:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;
  logic [11:0] b_addr;
  logic [7:0]  b_rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk_pix = ~clk_pix;

  text_writer #(.COLS(64), .ROWS(37), .ADDRW(12)) u_dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .buf_rd_addr(buf_rd_addr), .buf_rdata(buf_rdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  text_buffer_ram #(.COLS(64), .ROWS(37), .ADDRW(12)) u_ram (
    .clk_pix(clk_pix),
    .a_we(buf_we), .a_waddr(buf_addr), .a_wdata(buf_wdata),
    .a_raddr(buf_rd_addr), .a_rdata(buf_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the WRITE cycle.
  task automatic put(input logic [7:0] b);
    int unsigned n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clk_pix);
      n++;
    end
    if (!in_ready) check("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_char  = b;
    @(posedge clk_pix);
    @(negedge clk_pix);
    in_valid = 1'b0;
  endtask

  task automatic peek(input logic [11:0] a, output logic [7:0] d);
    b_addr = a;
    @(posedge clk_pix);
    @(negedge clk_pix);
    d = b_rdata;
  endtask

  task automatic expect_write(input string tag, input logic we, input logic [11:0] a,
                              input logic [7:0] d, input logic [5:0] col, input logic [5:0] row);
    check({tag, "_we"}, 32'(buf_we), 32'(we));
    if (we) begin
      check({tag, "_addr"}, 32'(buf_addr), 32'(a));
      check({tag, "_data"}, 32'(buf_wdata), 32'(d));
    end
    check({tag, "_col"}, 32'(cursor_col), 32'(col));
    check({tag, "_row"}, 32'(cursor_row), 32'(row));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  d;
    logic [7:0]  e;
    int unsigned idx;
    int unsigned bad;
    int unsigned cyc;
    int unsigned writes;

    rst_pix  = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    b_addr   = '0;
    repeat (3) @(negedge clk_pix);
    rst_pix = 1'b0;

    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(buf_we), 32'd0);
    check("rst_addr", 32'(buf_addr), 32'd0);
    check("rst_wdata", 32'(buf_wdata), 32'h20);
    check("rst_rd_addr", 32'(buf_rd_addr), 32'd0);
    check("rst_col", 32'(cursor_col), 32'd0);
    check("rst_row", 32'(cursor_row), 32'd0);

    // "Hi": one write each, ready low exactly one cycle per byte
    put(8'h48);
    expect_write("H", 1'b1, 12'd0, 8'h48, 6'd1, 6'd0);
    check("H_ready", 32'(in_ready), 32'd0);
    @(negedge clk_pix);
    check("H_we_drop", 32'(buf_we), 32'd0);
    check("H_ready_back", 32'(in_ready), 32'd1);
    put(8'h69);
    expect_write("i", 1'b1, 12'd1, 8'h69, 6'd2, 6'd0);
    @(negedge clk_pix);
    check("i_we_drop", 32'(buf_we), 32'd0);

    // ignored bytes still take a WRITE cycle
    put(8'h01);
    expect_write("ctl01", 1'b0, 12'd0, 8'h00, 6'd2, 6'd0);
    check("ctl01_busy", 32'(busy), 32'd1);
    put(8'h7F);
    expect_write("del", 1'b0, 12'd0, 8'h00, 6'd2, 6'd0);
    put(8'h0D);
    expect_write("cr", 1'b0, 12'd0, 8'h00, 6'd0, 6'd0);

    // BS at column 0 goes to the end of the previous row
    repeat (3) put(8'h0A);
    check("lf3_row", 32'(cursor_row), 32'd3);
    put(8'h08);
    expect_write("bs_wrap", 1'b1, 12'd191, 8'h20, 6'd63, 6'd2);

    // printable at the last column wraps to the next row
    put(8'h0D);
    repeat (3) put(8'h0A);
    repeat (63) put(8'h2E);
    check("pos63_col", 32'(cursor_col), 32'd63);
    check("pos63_row", 32'(cursor_row), 32'd5);
    put(8'h41);
    expect_write("A_wrap", 1'b1, 12'd383, 8'h41, 6'd0, 6'd6);
    @(negedge clk_pix);

    peek(12'd0, d);   check("mem0", 32'(d), 32'h48);
    peek(12'd1, d);   check("mem1", 32'(d), 32'h69);
    peek(12'd383, d); check("mem383", 32'(d), 32'h41);
    peek(12'd191, d); check("mem191", 32'(d), 32'h20);

    // FF: full clear, a byte held meanwhile waits for IDLE
    put(8'h0C);
    expect_write("ff", 1'b0, 12'd0, 8'h00, 6'd0, 6'd0);
    check("ff_busy", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_char  = 8'h78;
    idx = 0;
    bad = 0;
    for (int unsigned n = 0; n < 3000; n++) begin
      @(negedge clk_pix);
      if (in_ready) break;
      if (!buf_we || buf_addr != 12'(idx) || buf_wdata != 8'h20) bad++;
      idx++;
    end
    check("clr_all_len", idx, 32'd2368);
    check("clr_all_writes", bad, 32'd0);
    @(posedge clk_pix);
    @(negedge clk_pix);
    in_valid = 1'b0;
    expect_write("held_x", 1'b1, 12'd0, 8'h78, 6'd1, 6'd0);
    @(negedge clk_pix);
    peek(12'd383, d); check("cleared383", 32'(d), 32'h20);

    put(8'h08);
    expect_write("bs", 1'b1, 12'd0, 8'h20, 6'd0, 6'd0);
    put(8'h08);
    expect_write("bs_origin", 1'b0, 12'd0, 8'h00, 6'd0, 6'd0);

    // fill rows 0..35 with 0x30+r, ten 'T' in row 36, then LF to scroll
    for (int unsigned r = 0; r < ROWS - 1; r++)
      for (int unsigned c = 0; c < COLS; c++)
        put(8'(48 + r));
    repeat (10) put(8'h54);
    check("pre_col", 32'(cursor_col), 32'd10);
    check("pre_row", 32'(cursor_row), 32'd36);
    put(8'h0A);
    expect_write("lf_scroll", 1'b0, 12'd0, 8'h00, 6'd0, 6'd36);
    cyc = 0;
    writes = 0;
    for (int unsigned n = 0; n < 5000; n++) begin
      @(negedge clk_pix);
      if (in_ready) break;
      if (cyc == 0) begin
        check("scroll_c0_we", 32'(buf_we), 32'd0);
        check("scroll_c0_rd", 32'(buf_rd_addr), 32'd64);
      end
      if (cyc == 1) begin
        check("scroll_c1_we", 32'(buf_we), 32'd1);
        check("scroll_c1_addr", 32'(buf_addr), 32'd0);
        check("scroll_c1_data", 32'(buf_wdata), 32'h31);
      end
      if (buf_we) writes++;
      cyc++;
    end
    check("scroll_cycles", cyc, 32'd2369);
    check("scroll_writes", writes, 32'd2368);
    check("scroll_col", 32'(cursor_col), 32'd0);
    check("scroll_row", 32'(cursor_row), 32'd36);
    check("scroll_ready", 32'(in_ready), 32'd1);
    bad = 0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      peek(12'(i), d);
      if (i < 35 * COLS)       e = 8'(49 + i / COLS);
      else if (i < 36 * COLS)  e = ((i % COLS) < 10) ? 8'h54 : 8'h20;
      else                     e = 8'h20;
      if (d !== e) bad++;
    end
    check("scroll_content", bad, 32'd0);

    // reset during a scroll
    put(8'h0A);
    repeat (100) @(negedge clk_pix);
    check("mid_scroll_busy", 32'(busy), 32'd1);
    rst_pix = 1'b1;
    @(negedge clk_pix);
    rst_pix = 1'b0;
    check("rst_mid_we", 32'(buf_we), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    check("rst_mid_col", 32'(cursor_col), 32'd0);
    check("rst_mid_row", 32'(cursor_row), 32'd0);
    put(8'h5A);
    expect_write("Z_after_rst", 1'b1, 12'd0, 8'h5A, 6'd1, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
